compact_queue: RTL

COMPACT_QUEUE -- requirements
Module: compact_queue

---
 rtl/compact_queue_if.sv | 33 +++
 rtl/compact_queue.sv | 73 +++++++
 2 files changed

// File: rtl/compact_queue_if.sv
// compact_queue_if: handshake/data bundle for compact_queue.
//   push_valid/push_data : per-lane push request and payload (master -> slave)
//   pop                  : per-entry removal mask, bit i targets data[i] (master -> slave)
//   push_ready           : room for a full set of PushWidth lanes (slave -> master)
//   size/data/valid      : occupancy, entries (oldest at 0), thermometer mask (slave -> master)
//   empty/full           : size == 0 / size == Size (slave -> master)
interface compact_queue_if #(
  parameter int  Size      = 4,
  parameter type T         = bit [3:0],
  parameter int  PushWidth = 2
);
  localparam int SW = $clog2(Size + 1);

  logic [PushWidth-1:0] push_valid;
  T                     push_data [PushWidth];
  logic                 push_ready;
  logic [Size-1:0]      pop;
  logic [SW-1:0]        size;
  T                     data [Size];
  logic [Size-1:0]      valid;
  logic                 empty;
  logic                 full;

  modport master (
    output push_valid, push_data, pop,
    input  push_ready, size, data, valid, empty, full
  );

  modport slave (
    input  push_valid, push_data, pop,
    output push_ready, size, data, valid, empty, full
  );
endinterface

// File: rtl/compact_queue.sv
// compact_queue: small register-based queue with arbitrary per-entry removal.
// Each cycle the surviving entries (valid and not popped) slide down toward
// index 0 in order, then accepted push lanes are appended behind them.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears size and all entries
//   q     : compact_queue_if slave modport (push lanes, pop mask, state outputs)
module compact_queue #(
  parameter int  Size      = 4,
  parameter type T         = bit [3:0],
  parameter int  PushWidth = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  compact_queue_if.slave q
);
  localparam int SW = $clog2(Size + 1);
  localparam int IW = (Size > 1) ? $clog2(Size) : 1;

  logic [SW-1:0] size_q, size_d;
  T              data_q [Size];
  T              data_d [Size];
  logic [Size-1:0] valid;
  logic            push_ready;

  // Flags depend on registered size only, so a same-cycle pop never
  // makes room for a push.
  assign push_ready = (SW'(Size) - size_q) >= SW'(PushWidth);

  always_comb begin
    for (int i = 0; i < Size; i++) valid[i] = SW'(i) < size_q;
  end

  // Running prefix count of survivors gives each survivor its destination
  // slot; push lanes continue the same count so they land with no gaps.
  // Slots past the final count keep the zero default.
  always_comb begin
    logic [SW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < Size; i++) data_d[i] = '0;
    for (int i = 0; i < Size; i++) begin
      if (valid[i] && !q.pop[i]) begin
        if (cnt < SW'(Size)) data_d[cnt[IW-1:0]] = data_q[i];
        cnt = cnt + SW'(1);
      end
    end
    if (push_ready) begin
      for (int l = 0; l < PushWidth; l++) begin
        if (q.push_valid[l]) begin
          if (cnt < SW'(Size)) data_d[cnt[IW-1:0]] = q.push_data[l];
          cnt = cnt + SW'(1);
        end
      end
    end
    size_d = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q <= '0;
      for (int i = 0; i < Size; i++) data_q[i] <= '0;
    end else begin
      size_q <= size_d;
      for (int i = 0; i < Size; i++) data_q[i] <= data_d[i];
    end
  end

  assign q.size       = size_q;
  assign q.data       = data_q;
  assign q.valid      = valid;
  assign q.push_ready = push_ready;
  assign q.empty      = (size_q == '0);
  assign q.full       = (size_q == SW'(Size));
endmodule
